// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
// Bundles the hazard-detection inputs and the pipeline control, counter and
// status outputs of the hazard controller.
//   master : pipeline side, drives the hazard inputs and observes the controls
//   slave  : controller side, consumes the hazard inputs and drives the controls
// Hazard inputs : dmem_req_MEM, dmem_ready, branch_taken_EX, jump_ID,
//                 MemRead_EX, write_reg_EX, rs_ID, rt_ID, uses_rt_ID
// Controls      : *_Write register enables, *_flush bubble insertion
// Status        : stall_count, flush_count (CNT_W bits), mem_timeout, protocol_err
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             dmem_req_MEM;
  logic             dmem_ready;
  logic             branch_taken_EX;
  logic             jump_ID;
  logic             MemRead_EX;
  logic [4:0]       write_reg_EX;
  logic [4:0]       rs_ID;
  logic [4:0]       rt_ID;
  logic             uses_rt_ID;

  logic             PC_Write;
  logic             IF_ID_REG_Write;
  logic             ID_EX_REG_Write;
  logic             EX_MEM_REG_Write;
  logic             MEM_WB_REG_Write;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             EX_MEM_flush;
  logic             MEM_WB_flush;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             mem_timeout;
  logic             protocol_err;

  modport master (
    output dmem_req_MEM, dmem_ready, branch_taken_EX, jump_ID,
           MemRead_EX, write_reg_EX, rs_ID, rt_ID, uses_rt_ID,
    input  PC_Write, IF_ID_REG_Write, ID_EX_REG_Write, EX_MEM_REG_Write,
           MEM_WB_REG_Write, IF_ID_flush, ID_EX_flush, EX_MEM_flush,
           MEM_WB_flush, stall_count, flush_count, mem_timeout, protocol_err
  );

  modport slave (
    input  dmem_req_MEM, dmem_ready, branch_taken_EX, jump_ID,
           MemRead_EX, write_reg_EX, rs_ID, rt_ID, uses_rt_ID,
    output PC_Write, IF_ID_REG_Write, ID_EX_REG_Write, EX_MEM_REG_Write,
           MEM_WB_REG_Write, IF_ID_flush, ID_EX_flush, EX_MEM_flush,
           MEM_WB_flush, stall_count, flush_count, mem_timeout, protocol_err
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central sequencing controller for the five-stage pipeline. Drives the PC and
// pipeline-register enables/flushes combinationally, resolving hazards with
// fixed priority: memory wait > taken branch > load-use > jump. A two-state
// FSM tracks data-memory wait cycles; saturating counters record stalls and
// control-flow flushes, and sticky flags record timeouts and protocol errors.
// Ports:
//   clk     : single clock, all state updates on posedge
//   reset_n : synchronous reset, active HIGH despite its name
//   bus     : pipeline_hazard_ctrl_if.slave (hazard inputs, controls, status)
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t           state;
  logic [7:0]       wait_cnt;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic             timeout_q;
  logic             perr_q;

  logic mem_stall;
  logic load_use;
  logic branch_fire;
  logic jump_fire;

  assign mem_stall = bus.dmem_req_MEM & ~bus.dmem_ready;

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = bus.MemRead_EX && (bus.write_reg_EX != 5'd0) &&
                    ((bus.write_reg_EX == bus.rs_ID) ||
                     (bus.uses_rt_ID && (bus.write_reg_EX == bus.rt_ID)));

  // A suppressed rule is not lost: the frozen stage re-presents it later.
  assign branch_fire = ~reset_n & ~mem_stall & bus.branch_taken_EX;
  assign jump_fire   = ~reset_n & ~mem_stall & ~bus.branch_taken_EX &
                       ~load_use & bus.jump_ID;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    bus.PC_Write         = 1'b1;
    bus.IF_ID_REG_Write  = 1'b1;
    bus.ID_EX_REG_Write  = 1'b1;
    bus.EX_MEM_REG_Write = 1'b1;
    bus.MEM_WB_REG_Write = 1'b1;
    bus.IF_ID_flush      = 1'b0;
    bus.ID_EX_flush      = 1'b0;
    bus.EX_MEM_flush     = 1'b0;
    bus.MEM_WB_flush     = 1'b0;
    if (reset_n) begin
      bus.PC_Write         = 1'b0;
      bus.IF_ID_REG_Write  = 1'b0;
      bus.ID_EX_REG_Write  = 1'b0;
      bus.EX_MEM_REG_Write = 1'b0;
      bus.MEM_WB_REG_Write = 1'b0;
      bus.IF_ID_flush      = 1'b1;
      bus.ID_EX_flush      = 1'b1;
      bus.EX_MEM_flush     = 1'b1;
      bus.MEM_WB_flush     = 1'b1;
    end else if (mem_stall) begin
      // Freeze PC..EX/MEM; MEM/WB keeps loading a bubble so the instruction
      // held in MEM is written back exactly once.
      bus.PC_Write         = 1'b0;
      bus.IF_ID_REG_Write  = 1'b0;
      bus.ID_EX_REG_Write  = 1'b0;
      bus.EX_MEM_REG_Write = 1'b0;
      bus.MEM_WB_flush     = 1'b1;
    end else if (bus.branch_taken_EX) begin
      bus.IF_ID_flush = 1'b1;
      bus.ID_EX_flush = 1'b1;
    end else if (load_use) begin
      bus.PC_Write        = 1'b0;
      bus.IF_ID_REG_Write = 1'b0;
      bus.ID_EX_flush     = 1'b1;
    end else if (bus.jump_ID) begin
      bus.IF_ID_flush = 1'b1;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
      timeout_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      if ((state == MEM_WAIT) && (wait_cnt == TIMEOUT_CNT)) timeout_q <= 1'b1;

      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (bus.dmem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (!bus.dmem_req_MEM) begin
            // Request withdrawn before completion: abandon the wait.
            state  <= RUN;
            perr_q <= 1'b1;
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= RUN;
      endcase

      if (!bus.PC_Write && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if ((branch_fire || jump_fire) && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.stall_count  = stall_q;
  assign bus.flush_count  = flush_q;
  assign bus.mem_timeout  = timeout_q;
  assign bus.protocol_err = perr_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl. Two instances share one stimulus:
// dut_a uses the default parameters, dut_b uses CNT_W=4 and MEM_TIMEOUT=4 for
// the saturation and timeout cases. Inputs change 1 ns after posedge;
// combinational controls are checked mid-cycle, registered state 1 ns after
// the edge.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic reset_n;
  logic dmem_req, dmem_ready, branch, jump, mem_read, uses_rt;
  logic [4:0] wr_ex, rs, rt;

  int vectors     = 0;
  int miscompares = 0;

  // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB writes, IF_ID, ID_EX, EX_MEM, MEM_WB flushes}
  localparam logic [8:0] C_NORMAL = 9'b11111_0000;
  localparam logic [8:0] C_RESET  = 9'b00000_1111;
  localparam logic [8:0] C_MSTALL = 9'b00001_0001;
  localparam logic [8:0] C_BRANCH = 9'b11111_1100;
  localparam logic [8:0] C_LUSE   = 9'b00111_0100;
  localparam logic [8:0] C_JUMP   = 9'b11111_1000;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) bus_a ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  bus_b ();

  pipeline_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(255)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.slave)
  );
  pipeline_hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b.slave)
  );

  assign bus_a.dmem_req_MEM    = dmem_req;
  assign bus_a.dmem_ready      = dmem_ready;
  assign bus_a.branch_taken_EX = branch;
  assign bus_a.jump_ID         = jump;
  assign bus_a.MemRead_EX      = mem_read;
  assign bus_a.write_reg_EX    = wr_ex;
  assign bus_a.rs_ID           = rs;
  assign bus_a.rt_ID           = rt;
  assign bus_a.uses_rt_ID      = uses_rt;
  assign bus_b.dmem_req_MEM    = dmem_req;
  assign bus_b.dmem_ready      = dmem_ready;
  assign bus_b.branch_taken_EX = branch;
  assign bus_b.jump_ID         = jump;
  assign bus_b.MemRead_EX      = mem_read;
  assign bus_b.write_reg_EX    = wr_ex;
  assign bus_b.rs_ID           = rs;
  assign bus_b.rt_ID           = rt;
  assign bus_b.uses_rt_ID      = uses_rt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ctl_a();
    return {bus_a.PC_Write, bus_a.IF_ID_REG_Write, bus_a.ID_EX_REG_Write,
            bus_a.EX_MEM_REG_Write, bus_a.MEM_WB_REG_Write, bus_a.IF_ID_flush,
            bus_a.ID_EX_flush, bus_a.EX_MEM_flush, bus_a.MEM_WB_flush};
  endfunction

  function automatic logic [8:0] ctl_b();
    return {bus_b.PC_Write, bus_b.IF_ID_REG_Write, bus_b.ID_EX_REG_Write,
            bus_b.EX_MEM_REG_Write, bus_b.MEM_WB_REG_Write, bus_b.IF_ID_flush,
            bus_b.ID_EX_flush, bus_b.EX_MEM_flush, bus_b.MEM_WB_flush};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dmem_req = 1'b0; dmem_ready = 1'b0; branch = 1'b0; jump = 1'b0;
    mem_read = 1'b0; uses_rt = 1'b0; wr_ex = 5'd0; rs = 5'd0; rt = 5'd0;
  endtask

  task automatic do_reset();
    reset_n = 1'b1;
    #4 check("reset_ctl", 32'(ctl_a()), 32'(C_RESET));
    tick();
    reset_n = 1'b0;
  endtask

  initial begin
    // ---- reset with every input high ----
    reset_n = 1'b1;
    dmem_req = 1'b1; dmem_ready = 1'b1; branch = 1'b1; jump = 1'b1;
    mem_read = 1'b1; uses_rt = 1'b1; wr_ex = 5'h1f; rs = 5'h1f; rt = 5'h1f;
    #4 check("rst_ctl_c1", 32'(ctl_a()), 32'(C_RESET));
    tick();
    #4 check("rst_ctl_c2", 32'(ctl_b()), 32'(C_RESET));
    tick();
    reset_n = 1'b0;
    idle_inputs();
    #4 check("idle_ctl", 32'(ctl_a()), 32'(C_NORMAL));
    tick();
    check("rst_stall_a", 32'(bus_a.stall_count), 0);
    check("rst_flush_a", 32'(bus_a.flush_count), 0);
    check("rst_timeout_a", 32'(bus_a.mem_timeout), 0);
    check("rst_perr_a", 32'(bus_a.protocol_err), 0);
    check("rst_state_a", 32'(dut_a.state), 0);
    check("rst_stall_b", 32'(bus_b.stall_count), 0);

    // ---- load-use ----
    mem_read = 1'b1; wr_ex = 5'd5; rs = 5'd5;
    #4 check("lu_ctl", 32'(ctl_a()), 32'(C_LUSE));
    tick();
    mem_read = 1'b0;
    check("lu_stall1", 32'(bus_a.stall_count), 1);
    #4 check("lu_after_ctl", 32'(ctl_a()), 32'(C_NORMAL));
    tick();
    mem_read = 1'b1; wr_ex = 5'd0; rs = 5'd0;
    #4 check("lu_r0_ctl", 32'(ctl_a()), 32'(C_NORMAL));
    tick();
    check("lu_r0_stall", 32'(bus_a.stall_count), 1);
    wr_ex = 5'd7; rs = 5'd3; rt = 5'd7; uses_rt = 1'b1;
    #4 check("lu_rt_ctl", 32'(ctl_a()), 32'(C_LUSE));
    tick();
    uses_rt = 1'b0;
    #4 check("lu_rt_unused_ctl", 32'(ctl_a()), 32'(C_NORMAL));
    tick();
    check("lu_rt_stall", 32'(bus_a.stall_count), 2);
    idle_inputs();

    // ---- memory wait of 3 cycles ----
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4 check("mw_ctl", 32'(ctl_a()), 32'(C_MSTALL));
      tick();
      check("mw_state", 32'(dut_a.state), 1);
    end
    check("mw_stall3", 32'(bus_a.stall_count), 3);
    dmem_ready = 1'b1;
    #4 check("mw_done_ctl", 32'(ctl_a()), 32'(C_NORMAL));
    tick();
    check("mw_state_run", 32'(dut_a.state), 0);
    check("mw_stall_final", 32'(bus_a.stall_count), 3);
    // zero-wait access: no stall, no transition
    #4 check("zw_ctl", 32'(ctl_a()), 32'(C_NORMAL));
    tick();
    check("zw_state", 32'(dut_a.state), 0);
    check("zw_stall", 32'(bus_a.stall_count), 3);
    idle_inputs();

    // ---- priorities ----
    do_reset();
    branch = 1'b1; jump = 1'b1; mem_read = 1'b1; wr_ex = 5'd5; rs = 5'd5;
    #4 check("pri_all_ctl", 32'(ctl_a()), 32'(C_BRANCH));
    tick();
    check("pri_all_flush", 32'(bus_a.flush_count), 1);
    check("pri_all_stall", 32'(bus_a.stall_count), 0);
    branch = 1'b0; mem_read = 1'b0;
    #4 check("pri_jump_ctl", 32'(ctl_a()), 32'(C_JUMP));
    tick();
    check("pri_jump_flush", 32'(bus_a.flush_count), 2);
    mem_read = 1'b1;
    #4 check("pri_lu_jump_ctl", 32'(ctl_a()), 32'(C_LUSE));
    tick();
    check("pri_lu_jump_flush", 32'(bus_a.flush_count), 2);
    check("pri_lu_jump_stall", 32'(bus_a.stall_count), 1);
    mem_read = 1'b0; jump = 1'b0;
    branch = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #4 check("pri_ms_br_ctl", 32'(ctl_a()), 32'(C_MSTALL));
      tick();
      check("pri_ms_br_flush", 32'(bus_a.flush_count), 2);
    end
    dmem_ready = 1'b1;
    #4 check("pri_br_deferred_ctl", 32'(ctl_a()), 32'(C_BRANCH));
    tick();
    check("pri_br_deferred_flush", 32'(bus_a.flush_count), 3);
    check("pri_stall_total", 32'(bus_a.stall_count), 3);
    idle_inputs();

    // ---- timeout (dut_b, MEM_TIMEOUT=4) ----
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 4) check("to_not_yet_b", 32'(bus_b.mem_timeout), 0);
      if (i == 5) check("to_set_b", 32'(bus_b.mem_timeout), 1);
    end
    dmem_ready = 1'b1;
    tick();
    idle_inputs();
    tick();
    check("to_sticky_b", 32'(bus_b.mem_timeout), 1);
    check("to_state_b", 32'(dut_b.state), 0);
    check("to_none_a", 32'(bus_a.mem_timeout), 0);
    // reset in the middle of MEM_WAIT
    dmem_req = 1'b1; dmem_ready = 1'b0;
    tick();
    check("mid_rst_pre_state", 32'(dut_b.state), 1);
    do_reset();
    check("mid_rst_state_b", 32'(dut_b.state), 0);
    check("mid_rst_timeout_b", 32'(bus_b.mem_timeout), 0);
    idle_inputs();

    // ---- protocol error ----
    tick();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    tick();
    check("pe_wait_state", 32'(dut_a.state), 1);
    dmem_req = 1'b0;
    #4 check("pe_drop_ctl", 32'(ctl_a()), 32'(C_NORMAL));
    tick();
    check("pe_set_a", 32'(bus_a.protocol_err), 1);
    check("pe_state_a", 32'(dut_a.state), 0);
    tick();
    check("pe_sticky_b", 32'(bus_b.protocol_err), 1);

    // ---- counter saturation (dut_b, CNT_W=4) ----
    do_reset();
    mem_read = 1'b1; wr_ex = 5'd9; rs = 5'd9;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) check("sat_14_b", 32'(bus_b.stall_count), 14);
    end
    check("sat_hold_b", 32'(bus_b.stall_count), 15);
    check("sat_free_a", 32'(bus_a.stall_count), 20);
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central sequencing controller for the five-stage pipeline. Each cycle it drives the write-enable and flush controls of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves four hazard classes with fixed priority: data-memory wait, taken branch, load-use, and jump. It also tracks memory-wait cycles in a small FSM and keeps saturating performance/error counters.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush performance counters
- MEM_TIMEOUT, 255, MEM_WAIT cycle count at which mem_timeout is set (at most 255)

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset_n  in  1  reset is synchronous and active-high
- dmem_req_MEM  in  1  load/store instruction currently in MEM
- dmem_ready  in  1  data memory completes the access this cycle
- branch_taken_EX  in  1  branch resolved taken in EX
- jump_ID  in  1  jump decoded in ID
- MemRead_EX  in  1  instruction in EX is a load
- write_reg_EX  in  5  load destination register in EX
- rs_ID, rt_ID  in  5 each  source registers in ID
- uses_rt_ID  in  1  instruction in ID reads rt
- PC_Write, IF_ID_REG_Write, ID_EX_REG_Write, EX_MEM_REG_Write, MEM_WB_REG_Write  out  1 each  register enables
- IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush  out  1 each  bubble insertion
- stall_count  out  CNT_W  cycles with PC_Write=0, saturating
- flush_count  out  CNT_W  branch/jump flush events, saturating
- mem_timeout  out  1  sticky: MEM_WAIT reached MEM_TIMEOUT cycles
- protocol_err  out  1  sticky: dmem_req_MEM dropped while in MEM_WAIT with dmem_ready=0

## Operation
Control outputs are combinational from inputs and reset. Default state: all *_Write=1, all *_flush=0.

While reset_n=1:
- all *_Write=0
- all *_flush=1

Otherwise the first matching rule applies. Rules below are exclusive.
- Memory stall (mem_stall = dmem_req_MEM & ~dmem_ready):
  - PC_Write, IF_ID_REG_Write, ID_EX_REG_Write and EX_MEM_REG_Write = 0.
  - MEM_WB_flush=1, so WB receives a bubble and writeback is never duplicated.
  - All other flushes = 0.
- Branch (branch_taken_EX): IF_ID_flush=1 and ID_EX_flush=1.
- Load-use (MemRead_EX & write_reg_EX≠0 & (write_reg_EX==rs_ID | (uses_rt_ID & write_reg_EX==rt_ID))):
  - PC_Write=0 and IF_ID_REG_Write=0.
  - ID_EX_flush=1.
- Jump (jump_ID): IF_ID_flush=1.

Lower-priority events are not dropped. Frozen stages hold the instruction, so a suppressed condition re-presents itself and is acted on once the higher-priority condition clears.

FSM with states RUN and MEM_WAIT; reset state is RUN.
- RUN→MEM_WAIT when mem_stall. wait_cnt (8-bit) loads 1.
- MEM_WAIT, dmem_ready=1 → RUN. wait_cnt clears.
- MEM_WAIT, dmem_req_MEM=0 and dmem_ready=0 → RUN. protocol_err sets.
- MEM_WAIT otherwise: stay in MEM_WAIT and wait_cnt increments, saturating at 255.
- mem_timeout sets on any clock edge where the state is MEM_WAIT and wait_cnt==MEM_TIMEOUT.

Counters:
- stall_count increments on each non-reset cycle with PC_Write=0 (memory stall or load-use).
- flush_count increments on each non-reset cycle where the branch rule or the jump rule fires. Only one of the two can fire, so the increment is at most +1 per cycle.
- Both counters saturate at all-ones.

## Timing
- Reset values (sampled at the first edge with reset_n=1):
  - state=RUN, wait_cnt=0
  - stall_count=0, flush_count=0
  - mem_timeout=0, protocol_err=0
  - control outputs forced as in Operation.
- Reset asserted mid-MEM_WAIT: FSM returns to RUN and sticky flags clear at that edge.
- Control outputs have zero-cycle latency, valid in the same cycle as their inputs.
- Counters and flags update at the next posedge. They are visible one cycle after the causing cycle.
- A memory access completing with dmem_ready in its first MEM cycle causes no stall and no FSM transition.
- An access with N wait cycles (dmem_ready low for N cycles, then high):
  - freezes PC through EX/MEM for exactly N cycles;
  - inserts N MEM_WB bubbles;
  - adds N to stall_count.
- A load-use stall lasts exactly 1 cycle. Afterwards the load is in MEM, so the condition cannot recur.
- Branch and jump in the same cycle: the branch rule wins. flush_count increments once.
- Memory stall together with branch: no flush this cycle. The branch is acted on in the first non-stalled cycle.

## Test plan
- Reset: hold reset_n=1 for 2 cycles with all inputs high.
  - Required during reset: all Writes=0 and all flushes=1.
  - Required after release: counters=0, flags=0, state RUN.
- Load-use: MemRead_EX=1, write_reg_EX=5, rs_ID=5.
  - Required: PC_Write=0, IF_ID_REG_Write=0, ID_EX_flush=1 for 1 cycle; stall_count=1.
  - Repeat with write_reg_EX=0: required no stall.
- Memory wait: dmem_req_MEM=1 and dmem_ready=0 for 3 cycles, then dmem_ready=1.
  - Required: 3 frozen cycles with MEM_WB_flush=1, then all Writes=1; state back in RUN; stall_count=3.
- Priorities: assert branch_taken_EX, jump_ID and load-use together.
  - Required: only IF_ID_flush=1 and ID_EX_flush=1; flush_count=+1.
  - Then add mem_stall and confirm the branch flush is deferred until dmem_ready.
- Timeout and protocol error, each with MEM_TIMEOUT=4:
  - Hold dmem_ready=0 for 6 cycles: mem_timeout=1 and stays 1 after completion.
  - In MEM_WAIT, drop dmem_req_MEM with dmem_ready=0: protocol_err=1 and state RUN.
- Saturation: with CNT_W=4, run 20 load-use stalls. Required: stall_count holds at 15.
